// File: rtl/impulse_capture_sequencer.sv
// Repeated impulse-response capture: fire, skip a delay, accumulate N passes into impulse memory.
// Optional IMPULSE_AVG_NORM_EN adds a pass that divides the accumulated sum by the pass count.
module impulse_capture_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int ACC_W   = 20,
  parameter int MEM_LAT = 2
) (
  input  logic              audio_clk,
  input  logic              rst_in,
  input  logic              audio_trigger,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic [2:0]        passes_log2_in,
  input  logic [15:0]       delay_length_in,
  input  logic [15:0]       impulse_length_in,
  input  logic [15:0]       audio_in,
  input  logic              impulse_done_in,
  output logic              impulse_fire_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_we_out,
  output logic [ACC_W-1:0]  mem_wdata_out,
  input  logic [ACC_W-1:0]  mem_rdata_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [4:0]        pass_out,
  output logic              error_out
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT_IMP,
    S_DELAY,
    S_RECORD,
`ifdef IMPULSE_AVG_NORM_EN
    S_NORM,
`endif
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [LEN_W-1:0]  len, idx, len_in;
  logic [15:0]       delay, skip, sample;
  logic [2:0]        p2;
  logic [4:0]        pass;
  logic              error;
  logic [CNT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] waddr;
  logic              accept, overrun, norm_issue;
  logic              rmw_busy, write_now, have_more, last_pass;
  logic [ACC_W-1:0]  audio_ext, sample_ext;

  if (ADDR_W >= 16) begin : g_len_wide
    assign len_in = LEN_W'(impulse_length_in);
  end else begin : g_len_clamp
    localparam logic [15:0] MAX_LEN = 16'(1 << ADDR_W);
    assign len_in = (impulse_length_in > MAX_LEN) ? LEN_W'(MAX_LEN) : LEN_W'(impulse_length_in);
  end

  assign audio_ext  = {{(ACC_W-16){audio_in[15]}}, audio_in};
  assign sample_ext = {{(ACC_W-16){sample[15]}}, sample};
  assign rmw_busy   = (lat_cnt != '0);
  assign write_now  = (lat_cnt == CNT_W'(1));
  assign have_more  = (idx < len);
  assign last_pass  = (pass == ((5'd1 << p2) - 5'd1));

  assign impulse_fire_out = (state == S_FIRE);
  assign done_out         = (state == S_DONE);
  assign busy_out         = (state != S_IDLE) && (state != S_DONE);
  assign pass_out         = pass;
  assign error_out        = error;

  // The memory port is shared: a pending read-modify-write owns it until its write cycle.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    overrun       = 1'b0;
    norm_issue    = 1'b0;
    mem_addr_out  = '0;
    mem_we_out    = 1'b0;
    mem_wdata_out = '0;
    case (state)
      S_IDLE: if (start_in && impulse_length_in != 16'd0) state_next = S_FIRE;
      S_FIRE: state_next = S_WAIT_IMP;
      S_WAIT_IMP:
        if (impulse_done_in) state_next = (delay == 16'd0) ? S_RECORD : S_DELAY;
      S_DELAY:
        if (audio_trigger && skip == delay - 16'd1) state_next = S_RECORD;
      S_RECORD: begin
        if (audio_trigger && have_more) begin
          if (rmw_busy) begin
            overrun = 1'b1;
          end else begin
            accept       = 1'b1;
            mem_addr_out = idx[ADDR_W-1:0];
            if (pass == 5'd0) begin
              mem_we_out    = 1'b1;
              mem_wdata_out = audio_ext;
            end
          end
        end
        if (write_now) begin
          mem_we_out    = 1'b1;
          mem_addr_out  = waddr;
          mem_wdata_out = mem_rdata_in + sample_ext;
        end
        if (!have_more && !rmw_busy) begin
`ifdef IMPULSE_AVG_NORM_EN
          state_next = last_pass ? S_NORM : S_FIRE;
`else
          state_next = last_pass ? S_DONE : S_FIRE;
`endif
        end
      end
`ifdef IMPULSE_AVG_NORM_EN
      S_NORM: begin
        if (write_now) begin
          mem_we_out    = 1'b1;
          mem_addr_out  = waddr;
          mem_wdata_out = $signed(mem_rdata_in) >>> p2;
        end else if (have_more && !rmw_busy) begin
          norm_issue   = 1'b1;
          mem_addr_out = idx[ADDR_W-1:0];
        end
        if (!have_more && !rmw_busy) state_next = S_DONE;
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort_in && state != S_IDLE) begin
      state_next = S_IDLE;
      mem_we_out = 1'b0;
    end
  end

  always_ff @(posedge audio_clk) begin
    if (!rst_in) begin
      state   <= S_IDLE;
      len     <= '0;
      idx     <= '0;
      delay   <= '0;
      skip    <= '0;
      sample  <= '0;
      p2      <= '0;
      pass    <= '0;
      error   <= 1'b0;
      lat_cnt <= '0;
      waddr   <= '0;
    end else begin
      state <= state_next;

      if (state_next == S_IDLE)
        lat_cnt <= '0;
      else if ((accept && pass != 5'd0) || norm_issue)
        lat_cnt <= CNT_W'(MEM_LAT);
      else if (rmw_busy)
        lat_cnt <= lat_cnt - CNT_W'(1);

      case (state)
        S_IDLE:
          if (start_in) begin
            len   <= len_in;
            delay <= delay_length_in;
            p2    <= (passes_log2_in > 3'd4) ? 3'd4 : passes_log2_in;
            if (impulse_length_in == 16'd0) begin
              error <= 1'b1;
            end else begin
              error <= 1'b0;
              pass  <= 5'd0;
            end
          end
        S_FIRE: begin
          idx  <= '0;
          skip <= '0;
        end
        S_DELAY: if (audio_trigger) skip <= skip + 16'd1;
        S_RECORD: begin
          // Dropped samples still consume their address slot.
          if (accept || overrun) idx <= idx + LEN_W'(1);
          if (accept) begin
            sample <= audio_in;
            waddr  <= idx[ADDR_W-1:0];
          end
          if (overrun) error <= 1'b1;
          if (state_next == S_FIRE) pass <= pass + 5'd1;
`ifdef IMPULSE_AVG_NORM_EN
          if (state_next == S_NORM) idx <= '0;
`endif
        end
`ifdef IMPULSE_AVG_NORM_EN
        S_NORM:
          if (norm_issue) begin
            idx   <= idx + LEN_W'(1);
            waddr <= idx[ADDR_W-1:0];
          end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_impulse_capture_sequencer.sv
// Randomized bench for impulse_capture_sequencer with a BRAM model and a per-address sum reference.
module tb_impulse_capture_sequencer;

  localparam int ADDR_W  = 16;
  localparam int ACC_W   = 20;
  localparam int MEM_LAT = 2;

  logic              audio_clk = 1'b0;
  logic              rst_in;
  logic              audio_trigger;
  logic              start_in;
  logic              abort_in;
  logic [2:0]        passes_log2_in;
  logic [15:0]       delay_length_in;
  logic [15:0]       impulse_length_in;
  logic [15:0]       audio_in;
  logic              impulse_done_in;
  logic              impulse_fire_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_we_out;
  logic [ACC_W-1:0]  mem_wdata_out;
  logic [ACC_W-1:0]  mem_rdata_in;
  logic              busy_out;
  logic              done_out;
  logic [4:0]        pass_out;
  logic              error_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fire_count = 0;
  int done_count = 0;
  int we_count = 0;
  int sample_table[$];
  logic scrub = 1'b0;

  logic [ACC_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ACC_W-1:0] rd_pipe [MEM_LAT];

  impulse_capture_sequencer #(.ADDR_W(ADDR_W), .ACC_W(ACC_W), .MEM_LAT(MEM_LAT)) dut (
    .audio_clk(audio_clk), .rst_in(rst_in), .audio_trigger(audio_trigger),
    .start_in(start_in), .abort_in(abort_in), .passes_log2_in(passes_log2_in),
    .delay_length_in(delay_length_in), .impulse_length_in(impulse_length_in),
    .audio_in(audio_in), .impulse_done_in(impulse_done_in),
    .impulse_fire_out(impulse_fire_out), .mem_addr_out(mem_addr_out),
    .mem_we_out(mem_we_out), .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in),
    .busy_out(busy_out), .done_out(done_out), .pass_out(pass_out), .error_out(error_out)
  );

  initial forever #5 audio_clk = ~audio_clk;

  // BRAM model: read data appears MEM_LAT cycles after the address; scrub fills junk.
  always @(posedge audio_clk) begin
    cyc <= cyc + 1;
    if (scrub)
      for (int i = 0; i < 64; i++) mem[i] <= ACC_W'($urandom);
    else if (mem_we_out)
      mem[mem_addr_out] <= mem_wdata_out;
    rd_pipe[0] <= mem[mem_addr_out];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata_in = rd_pipe[MEM_LAT-1];

  always @(negedge audio_clk) begin
    if (impulse_fire_out) fire_count++;
    if (done_out) done_count++;
    if (mem_we_out) we_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge audio_clk);
    #1;
  endtask

  task automatic strobe(input int v);
    audio_trigger = 1'b1;
    audio_in      = 16'(v);
    tick();
    audio_trigger = 1'b0;
  endtask

  task automatic wait_fire(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge audio_clk);
      if (impulse_fire_out) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("fire_seen", longint'(ok), 1);
    if (ok) checkOutput("pass_at_fire", longint'(pass_out), p);
  endtask

  // One full measurement; the reference sums accepted samples per address, a strobe in
  // pass>0 within MEM_LAT cycles of the last accepted one is dropped and flags an error.
  task automatic applyStimulus(input int p2_raw, input int dly, input int len,
                               input int overrun_pass, input int abort_pass, input int abort_after);
    int     p2c, passes, fire0, done0, we0, last_acc, gap, v;
    longint exp_sum[64];
    longint exp_val;
    bit     exp_err, ok;
    p2c     = (p2_raw > 4) ? 4 : p2_raw;
    passes  = 1 << p2c;
    exp_err = 1'b0;
    for (int k = 0; k < 64; k++) exp_sum[k] = 0;
    scrub = 1'b1;
    tick();
    scrub = 1'b0;
    fire0 = fire_count;
    done0 = done_count;

    start_in          = 1'b1;
    passes_log2_in    = 3'(p2_raw);
    delay_length_in   = 16'(dly);
    impulse_length_in = 16'(len);
    tick();
    start_in          = 1'b0;
    passes_log2_in    = 3'($urandom);
    delay_length_in   = 16'($urandom_range(0, 40));
    impulse_length_in = 16'($urandom_range(0, 40));
    checkOutput("error_cleared", longint'(error_out), 0);
    checkOutput("busy_after_start", longint'(busy_out), 1);

    for (int p = 0; p < passes; p++) begin
      wait_fire(p, ok);
      if (!ok) return;
      tick();
      repeat ($urandom_range(0, 3)) tick();
      impulse_done_in = 1'b1;
      if (p == 0) start_in = 1'b1;
      tick();
      impulse_done_in = 1'b0;
      start_in        = 1'b0;
      tick();
      for (int j = 0; j < dly; j++) begin
        strobe(int'($urandom_range(0, 65535)) - 32768);
        repeat ($urandom_range(0, 2)) tick();
      end
      last_acc = -1000;
      for (int k = 0; k < len; k++) begin
        if (k > 0) begin
          if (p == 0) gap = $urandom_range(1, 4);
          else if (p == overrun_pass && k == 1) gap = 1;
          else gap = $urandom_range(MEM_LAT + 1, MEM_LAT + 3);
          repeat (gap - 1) tick();
        end
        if (sample_table.size() > 0) v = sample_table.pop_front();
        else v = int'($urandom_range(0, 65535)) - 32768;
        if (p == 0) begin
          exp_sum[k] = v;
          last_acc   = cyc;
        end else if (cyc - last_acc > MEM_LAT) begin
          exp_sum[k] = exp_sum[k] + v;
          last_acc   = cyc;
        end else begin
          exp_err = 1'b1;
        end
        strobe(v);
        if (p == abort_pass && k == abort_after - 1) begin
          abort_in = 1'b1;
          tick();
          abort_in = 1'b0;
          we0 = we_count;
          done0 = done_count;
          @(negedge audio_clk);
          checkOutput("abort_busy", longint'(busy_out), 0);
          repeat (10) tick();
          checkOutput("abort_no_write", we_count - we0, 0);
          checkOutput("abort_no_done", done_count - done0, 0);
          checkOutput("abort_fires", fire_count - fire0, p + 1);
          checkOutput("abort_idle_busy", longint'(busy_out), 0);
          return;
        end
      end
    end

    ok = 1'b0;
    for (int i = 0; i < 100 + len * 8; i++) begin
      @(negedge audio_clk);
      if (done_out) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", longint'(ok), 1);
    if (ok) checkOutput("busy_at_done", longint'(busy_out), 0);
    repeat (3) tick();
    checkOutput("done_pulses", done_count - done0, 1);
    checkOutput("fire_pulses", fire_count - fire0, passes);
    checkOutput("busy_idle", longint'(busy_out), 0);
    checkOutput("error", longint'(error_out), longint'(exp_err));
    for (int k = 0; k < len; k++) begin
`ifdef IMPULSE_AVG_NORM_EN
      exp_val = exp_sum[k] >>> p2c;
`else
      exp_val = exp_sum[k];
`endif
      checkOutput($sformatf("mem[%0d]", k), longint'($signed(mem[k])), exp_val);
    end
  endtask

  initial begin
    rst_in            = 1'b0;
    audio_trigger     = 1'b0;
    start_in          = 1'b0;
    abort_in          = 1'b0;
    passes_log2_in    = '0;
    delay_length_in   = '0;
    impulse_length_in = '0;
    audio_in          = '0;
    impulse_done_in   = 1'b0;
    repeat (3) tick();
    @(negedge audio_clk);
    checkOutput("rst_fire", longint'(impulse_fire_out), 0);
    checkOutput("rst_we", longint'(mem_we_out), 0);
    checkOutput("rst_addr", longint'(mem_addr_out), 0);
    checkOutput("rst_wdata", longint'(mem_wdata_out), 0);
    checkOutput("rst_busy", longint'(busy_out), 0);
    checkOutput("rst_done", longint'(done_out), 0);
    checkOutput("rst_pass", longint'(pass_out), 0);
    checkOutput("rst_error", longint'(error_out), 0);
    tick();
    rst_in = 1'b1;
    tick();

    sample_table = {10, 20, 30, 40};
    applyStimulus(0, 3, 4, -1, -1, 0);

    sample_table = {5, -7, 3, 1};
    applyStimulus(1, 2, 2, -1, -1, 0);

    for (int i = 0; i < 32; i++) sample_table.push_back(-32768);
    applyStimulus(7, 1, 2, -1, -1, 0);
`ifdef IMPULSE_AVG_NORM_EN
    checkOutput("fullscale_const", longint'($signed(mem[0])), -32768);
`else
    checkOutput("fullscale_const", longint'($signed(mem[0])), -524288);
`endif

    applyStimulus(2, 0, 5, -1, -1, 0);

    begin
      int f0;
      f0 = fire_count;
      start_in          = 1'b1;
      impulse_length_in = 16'd0;
      tick();
      start_in = 1'b0;
      @(negedge audio_clk);
      checkOutput("zero_len_error", longint'(error_out), 1);
      checkOutput("zero_len_busy", longint'(busy_out), 0);
      repeat (5) tick();
      checkOutput("zero_len_idle", longint'(busy_out), 0);
      checkOutput("zero_len_fires", fire_count - f0, 0);
    end

    for (int t = 0; t < 6; t++)
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(1, 12), -1, -1, 0);

    applyStimulus(2, 1, 6, -1, 1, 3);
    applyStimulus(1, 2, 3, -1, -1, 0);
    applyStimulus(1, 1, 4, 1, -1, 0);

    rst_in = 1'b0;
    tick();
    checkOutput("reset_clears_error", longint'(error_out), 0);
    checkOutput("reset_busy", longint'(busy_out), 0);
    checkOutput("reset_pass", longint'(pass_out), 0);
    rst_in = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
